// File: rtl/fmem_rw_arbiter_if.sv
// Bus bundle between the pixel packer, display prefetcher, frame memory macro
// and the read/write arbiter that shares that memory between them.
interface fmem_rw_arbiter_if #(
   parameter int MEM_WIDTH  = 96,
   parameter int ADDR_WIDTH = 15
);
   logic                  i_wr_req;
   logic [ADDR_WIDTH-1:0] i_wr_addr;
   logic [MEM_WIDTH-1:0]  i_wr_data;
   logic                  o_wr_gnt;
   logic                  i_rd_req;
   logic [ADDR_WIDTH-1:0] i_rd_addr;
   logic                  o_rd_gnt;
   logic                  o_rd_valid;
   logic [MEM_WIDTH-1:0]  o_rd_data;
   logic                  o_fmem_csn;
   logic                  o_fmem_wen;
   logic [ADDR_WIDTH-1:0] o_fmem_addr;
   logic [MEM_WIDTH-1:0]  o_fmem_din;
   logic [MEM_WIDTH-1:0]  i_fmem_dout;
   logic                  i_clr;
   logic                  o_starve;
   logic                  o_addr_err;

   // Environment side: requesters, memory macro and status host.
   modport master (
      output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_fmem_dout, i_clr,
      input  o_wr_gnt, o_rd_gnt, o_rd_valid, o_rd_data, o_fmem_csn, o_fmem_wen,
             o_fmem_addr, o_fmem_din, o_starve, o_addr_err
   );

   // Arbiter side.
   modport slave (
      input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_fmem_dout, i_clr,
      output o_wr_gnt, o_rd_gnt, o_rd_valid, o_rd_data, o_fmem_csn, o_fmem_wen,
             o_fmem_addr, o_fmem_din, o_starve, o_addr_err
   );
endinterface

// File: rtl/fmem_rw_arbiter.sv
// Read-priority arbiter for the single-port frame memory, with a bounded
// write-starvation counter and registered memory pins / read data.
module fmem_rw_arbiter #(
   parameter int DATA_WIDTH   = 24,
   parameter int PIX_PER_WORD = 4,
   parameter int MEM_WIDTH    = DATA_WIDTH * PIX_PER_WORD,
   parameter int ADDR_DEPTH   = 19200,
   parameter int ADDR_WIDTH   = $clog2(ADDR_DEPTH),
   parameter int WR_MAX_WAIT  = 8
) (
   input logic             i_clk,
   input logic             rst_n,
   fmem_rw_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WR_F} state_t;

   state_t     state;
   state_t     next_state;
   logic [7:0] wait_cnt;
   logic       force_wr;
   logic       wr_gnt;
   logic       rd_gnt;
   logic       wr_hs;
   logic       rd_hs;
   logic       wr_bad;
   logic       rd_bad;
   logic       rd_bad_p1;
   logic       rd_p2;
   logic       rd_bad_p2;

   assign force_wr   = bus.i_wr_req & (wait_cnt >= 8'(WR_MAX_WAIT));
   assign wr_gnt     = bus.i_wr_req & (~bus.i_rd_req | force_wr);
   assign rd_gnt     = bus.i_rd_req & ~force_wr;
   assign bus.o_wr_gnt = wr_gnt;
   assign bus.o_rd_gnt = rd_gnt;
   assign wr_hs      = bus.i_wr_req & wr_gnt;
   assign rd_hs      = bus.i_rd_req & rd_gnt;
   assign wr_bad     = 32'(bus.i_wr_addr) >= ADDR_DEPTH;
   assign rd_bad     = 32'(bus.i_rd_addr) >= ADDR_DEPTH;

   // The state names the command type that goes to memory next cycle.
   always_comb begin
      next_state = S_IDLE;
      if (wr_hs) begin
         next_state = force_wr ? S_WR_F : S_WR;
      end else if (rd_hs) begin
         next_state = S_RD;
      end
   end

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Saturating count of consecutive cycles a pending write was denied.
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 8'd0;
      end else if (bus.i_wr_req & ~wr_gnt) begin
         if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end else begin
         wait_cnt <= 8'd0;
      end
   end

   // Memory pins, read-return pipeline and sticky status flags. Out-of-range
   // requests are acknowledged but never reach the macro; a suppressed read
   // still returns a zero word so the read client stays in step.
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.o_fmem_csn  <= 1'b1;
         bus.o_fmem_wen  <= 1'b1;
         bus.o_fmem_addr <= '0;
         bus.o_fmem_din  <= '0;
         bus.o_rd_valid  <= 1'b0;
         bus.o_rd_data   <= '0;
         bus.o_starve    <= 1'b0;
         bus.o_addr_err  <= 1'b0;
         rd_bad_p1       <= 1'b0;
         rd_p2           <= 1'b0;
         rd_bad_p2       <= 1'b0;
      end else begin
         bus.o_fmem_csn <= 1'b1;
         bus.o_fmem_wen <= 1'b1;
         if (wr_hs && !wr_bad) begin
            bus.o_fmem_csn  <= 1'b0;
            bus.o_fmem_wen  <= 1'b0;
            bus.o_fmem_addr <= bus.i_wr_addr;
            bus.o_fmem_din  <= bus.i_wr_data;
         end else if (rd_hs && !rd_bad) begin
            bus.o_fmem_csn  <= 1'b0;
            bus.o_fmem_addr <= bus.i_rd_addr;
         end
         rd_bad_p1     <= rd_hs & rd_bad;
         rd_p2         <= (state == S_RD);
         rd_bad_p2     <= rd_bad_p1;
         bus.o_rd_valid <= rd_p2;
         if (rd_p2) begin
            bus.o_rd_data <= rd_bad_p2 ? '0 : bus.i_fmem_dout;
         end
         bus.o_starve   <= (next_state == S_WR_F) | (bus.o_starve & ~bus.i_clr);
         bus.o_addr_err <= (wr_hs & wr_bad) | (rd_hs & rd_bad) | (bus.o_addr_err & ~bus.i_clr);
      end
   end

endmodule

// File: tb/tb_fmem_rw_arbiter.sv
// Randomised and directed bench for fmem_rw_arbiter against a cycle-level
// reference model of the grant rules, a shadow memory and a read-return queue.
module tb_fmem_rw_arbiter;

   localparam int MEMW  = 96;
   localparam int ADRW  = 15;
   localparam int DEPTH = 19200;

   logic i_clk;
   logic rst_n;

   fmem_rw_arbiter_if #(.MEM_WIDTH(MEMW), .ADDR_WIDTH(ADRW)) bus ();

   fmem_rw_arbiter dut (
      .i_clk (i_clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Frame memory macro: 1-cycle read latency, active-low controls.
   logic [MEMW-1:0] mem [0:DEPTH-1];
   always @(posedge i_clk) begin
      if (!bus.o_fmem_csn && (bus.o_fmem_addr < 15'(DEPTH))) begin
         if (!bus.o_fmem_wen) begin
            mem[bus.o_fmem_addr] <= bus.o_fmem_din;
         end else begin
            bus.i_fmem_dout <= mem[bus.o_fmem_addr];
         end
      end
   end

   typedef struct {
      int              due;
      logic [MEMW-1:0] data;
   } rdExp_t;

   int              numChecks = 0;
   int              numErrors = 0;
   int              cyc = 0;
   int              wcnt;
   logic            mCsn, mWen, mStarve, mAddrErr;
   logic [ADRW-1:0] mAddr;
   logic [MEMW-1:0] mDin, mRdData;
   logic [MEMW-1:0] shadow [int];
   rdExp_t          rdq [$];
   bit              hsWr, hsRd, dutWrGnt, dutRdGnt;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      numChecks++;
      if (obs !== exp) begin
         numErrors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic modelReset();
      wcnt = 0;  mCsn = 1'b1;  mWen = 1'b1;  mStarve = 1'b0;  mAddrErr = 1'b0;
      mAddr = '0;  mDin = '0;  mRdData = '0;
      rdq.delete();
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_csn"},     128'(bus.o_fmem_csn),  128'(1));
      checkOutput({tag, "_wen"},     128'(bus.o_fmem_wen),  128'(1));
      checkOutput({tag, "_addr"},    128'(bus.o_fmem_addr), 128'(0));
      checkOutput({tag, "_din"},     128'(bus.o_fmem_din),  128'(0));
      checkOutput({tag, "_rdvalid"}, 128'(bus.o_rd_valid),  128'(0));
      checkOutput({tag, "_rddata"},  128'(bus.o_rd_data),   128'(0));
      checkOutput({tag, "_starve"},  128'(bus.o_starve),    128'(0));
      checkOutput({tag, "_addrerr"}, 128'(bus.o_addr_err),  128'(0));
   endtask

   // Compare this cycle's DUT outputs with the model, then advance the model.
   task automatic evaluateCycle();
      bit frc, eWr, eRd, wb, rb, expV;
      frc = bus.i_wr_req && (wcnt >= 8);
      eWr = bus.i_wr_req && (!bus.i_rd_req || frc);
      eRd = bus.i_rd_req && !frc;
      dutWrGnt = bus.o_wr_gnt;
      dutRdGnt = bus.o_rd_gnt;
      checkOutput("wr_gnt", 128'(bus.o_wr_gnt), 128'(eWr));
      checkOutput("rd_gnt", 128'(bus.o_rd_gnt), 128'(eRd));
      checkOutput("fmem_csn", 128'(bus.o_fmem_csn), 128'(mCsn));
      checkOutput("fmem_wen", 128'(bus.o_fmem_wen), 128'(mWen));
      if (!mCsn) checkOutput("fmem_addr", 128'(bus.o_fmem_addr), 128'(mAddr));
      checkOutput("fmem_din", 128'(bus.o_fmem_din), 128'(mDin));
      expV = (rdq.size() > 0) && (rdq[0].due == cyc);
      if (expV) mRdData = rdq.pop_front().data;
      checkOutput("rd_valid", 128'(bus.o_rd_valid), 128'(expV));
      checkOutput("rd_data", 128'(bus.o_rd_data), 128'(mRdData));
      checkOutput("starve", 128'(bus.o_starve), 128'(mStarve));
      checkOutput("addr_err", 128'(bus.o_addr_err), 128'(mAddrErr));

      wb = eWr && (int'(bus.i_wr_addr) >= DEPTH);
      rb = eRd && (int'(bus.i_rd_addr) >= DEPTH);
      mStarve  = (eWr && frc) || (mStarve && !bus.i_clr);
      mAddrErr = wb || rb || (mAddrErr && !bus.i_clr);
      mCsn = 1'b1;
      mWen = 1'b1;
      if (eWr && !wb) begin
         mCsn = 1'b0;  mWen = 1'b0;
         mAddr = bus.i_wr_addr;  mDin = bus.i_wr_data;
         shadow[int'(bus.i_wr_addr)] = bus.i_wr_data;
      end
      if (eRd) begin
         rdExp_t e;
         e.due  = cyc + 3;
         e.data = '0;
         if (!rb) begin
            mCsn = 1'b0;
            mAddr = bus.i_rd_addr;
            if (shadow.exists(int'(bus.i_rd_addr))) e.data = shadow[int'(bus.i_rd_addr)];
         end
         rdq.push_back(e);
      end
      if (bus.i_wr_req && !eWr) wcnt = (wcnt >= 255) ? 255 : wcnt + 1;
      else                      wcnt = 0;
      hsWr = eWr;
      hsRd = eRd;
      cyc++;
   endtask

   // One clock cycle: drive at posedge+1, check at negedge.
   task automatic applyStimulus(input bit wrReq, input logic [ADRW-1:0] wrAddr,
                                input logic [MEMW-1:0] wrData, input bit rdReq,
                                input logic [ADRW-1:0] rdAddr, input bit clr);
      bus.i_wr_req  = wrReq;
      bus.i_wr_addr = wrAddr;
      bus.i_wr_data = wrData;
      bus.i_rd_req  = rdReq;
      bus.i_rd_addr = rdAddr;
      bus.i_clr     = clr;
      @(negedge i_clk);
      evaluateCycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   function automatic logic [ADRW-1:0] randAddr();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return 15'(DEPTH + $urandom_range(0, 50));
      if (r == 1) return 15'(DEPTH - 1);
      return 15'($urandom_range(0, 63));
   endfunction

   initial begin
      logic [MEMW-1:0] word;
      logic [ADRW-1:0] wa, ra;
      logic [MEMW-1:0] wd;
      int              cnt;
      bit              wp, rp;

      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      bus.i_fmem_dout = '0;
      bus.i_wr_req = 1'b0;  bus.i_wr_addr = '0;  bus.i_wr_data = '0;
      bus.i_rd_req = 1'b0;  bus.i_rd_addr = '0;  bus.i_clr = 1'b0;
      rst_n = 1'b0;
      modelReset();
      repeat (3) @(posedge i_clk);
      #1;
      checkResetValues("reset");
      rst_n = 1'b1;

      $display("[TB] idle after reset");
      idle(10);

      $display("[TB] single write then read");
      word = 96'hA5A5A5_5A5A5A_123456_FEDCBA;
      applyStimulus(1'b1, 15'h005, word, 1'b0, '0, 1'b0);
      idle(1);
      applyStimulus(1'b0, '0, '0, 1'b1, 15'h005, 1'b0);
      idle(5);

      $display("[TB] read streaming");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 15'(i), {$urandom, $urandom, $urandom}, 1'b0, '0, 1'b0);
      end
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, '0, '0, 1'b1, 15'(i), 1'b0);
         if (dutRdGnt) cnt++;
      end
      checkOutput("stream_gnt_count", 128'(cnt), 128'(16));
      idle(5);

      $display("[TB] starvation");
      wa = 15'd100;  ra = 15'd0;  wd = {$urandom, $urandom, $urandom};
      cnt = 0;
      for (int i = 0; i < 36; i++) begin
         applyStimulus(1'b1, wa, wd, 1'b1, ra, (i == 8) || (i == 12));
         if (dutWrGnt) cnt++;
         if (hsWr) begin wa = wa + 15'd1; wd = {$urandom, $urandom, $urandom}; end
         if (hsRd) ra = ra + 15'd1;
      end
      checkOutput("starve_wr_gnt_count", 128'(cnt), 128'(4));
      idle(5);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);

      $display("[TB] address error");
      applyStimulus(1'b0, '0, '0, 1'b1, 15'(DEPTH), 1'b0);
      idle(1);
      applyStimulus(1'b0, '0, '0, 1'b1, 15'h005, 1'b0);
      idle(5);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
      idle(2);

      $display("[TB] reset mid-read");
      applyStimulus(1'b0, '0, '0, 1'b1, 15'h003, 1'b0);
      bus.i_rd_req = 1'b0;
      rst_n = 1'b0;
      #1;
      checkResetValues("midreset");
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      rst_n = 1'b1;
      modelReset();
      idle(6);

      $display("[TB] random traffic");
      wp = 1'b0;  rp = 1'b0;  wa = '0;  ra = '0;  wd = '0;
      for (int n = 0; n < 2000; n++) begin
         if (!wp && ($urandom_range(0, 2) == 0)) begin
            wp = 1'b1;  wa = randAddr();  wd = {$urandom, $urandom, $urandom};
         end
         if (!rp && ($urandom_range(0, 1) == 0)) begin
            rp = 1'b1;  ra = randAddr();
         end
         applyStimulus(wp, wa, wd, rp, ra, $urandom_range(0, 31) == 0);
         if (hsWr) wp = 1'b0;
         if (hsRd) rp = 1'b0;
      end
      idle(6);

      $display("test done: total=%0d bad=%0d", numChecks, numErrors);
      $finish;
   end

endmodule

// File: doc/fmem_rw_arbiter.md
Name: fmem_rw_arbiter

Overview:
- Shares the single-port frame memory between two requesters:
  - a write client, the input-side pixel packer storing 4-pixel words;
  - a read client, the display-side prefetcher feeding the sync-timed output stream.
- Reads have priority because display underrun is fatal. A wait counter bounds write starvation.
- Sits between the requesters and the frame memory macro (CSN/WEN active-low, 1-cycle read latency). All memory pins and read data are registered.

Parameters:
- DATA_WIDTH, 24, bits per pixel
- PIX_PER_WORD, 4, pixels per memory word
- MEM_WIDTH, DATA_WIDTH*PIX_PER_WORD, memory word width
- ADDR_DEPTH, 19200, memory words (320*240/4)
- ADDR_WIDTH, $clog2(ADDR_DEPTH), address width
- WR_MAX_WAIT, 8, consecutive denied write cycles before a forced write grant (range 1..255)

Ports:
- i_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_wr_req  in  1  write request; held with addr/data until granted
- i_wr_addr  in  ADDR_WIDTH  write word address
- i_wr_data  in  MEM_WIDTH  write word
- o_wr_gnt  out  1  write grant (combinational); transfer when i_wr_req & o_wr_gnt
- i_rd_req  in  1  read request; held with addr until granted
- i_rd_addr  in  ADDR_WIDTH  read word address
- o_rd_gnt  out  1  read grant (combinational)
- o_rd_valid  out  1  read data valid strobe
- o_rd_data  out  MEM_WIDTH  read word
- o_fmem_csn  out  1  memory chip select, active-low
- o_fmem_wen  out  1  memory write enable, active-low
- o_fmem_addr  out  ADDR_WIDTH  memory address
- o_fmem_din  out  MEM_WIDTH  memory write data
- i_fmem_dout  in  MEM_WIDTH  memory read data, valid the cycle after a read command
- i_clr  in  1  synchronous clear of sticky status flags
- o_starve  out  1  sticky: a forced write grant occurred
- o_addr_err  out  1  sticky: a granted request had address >= ADDR_DEPTH

Behaviour:
- Reset values (async assert, sync release):
  - o_fmem_csn=1, o_fmem_wen=1; o_fmem_addr, o_fmem_din, o_rd_data = 0
  - o_rd_valid=0, o_starve=0, o_addr_err=0
  - wait counter=0, FSM=S_IDLE, read pipeline valid bits cleared
- Grant decision (combinational, per cycle):
  - force = i_wr_req & (wait_cnt >= WR_MAX_WAIT)
  - o_wr_gnt = i_wr_req & (~i_rd_req | force)
  - o_rd_gnt = i_rd_req & ~force
  - At most one grant per cycle.
- Wait counter (8-bit, saturating at 255):
  - increments when i_wr_req & ~o_wr_gnt;
  - clears on write grant or when i_wr_req low.
- FSM states record the command type issued to memory in the next cycle:
  - S_IDLE: no handshake.
  - S_RD: read handshake.
  - S_WR: normal write handshake.
  - S_WR_F: forced write handshake.
  - Next state is chosen every cycle from the handshake in that cycle.
  - Any state may go to any state; there are no dwell cycles, so back-to-back transfers run at 1 per cycle.
- Command pipeline (handshake in cycle c):
  - Cycle c+1: o_fmem_csn=0.
    - Write: o_fmem_wen=0, o_fmem_addr=i_wr_addr(c), o_fmem_din=i_wr_data(c).
    - Read: o_fmem_wen=1, o_fmem_addr=i_rd_addr(c); o_fmem_din holds its last value.
  - No handshake in c: o_fmem_csn=1, o_fmem_wen=1 in c+1.
  - Read: i_fmem_dout valid in c+2. o_rd_data is registered from it, and o_rd_valid=1 in c+3 for exactly one cycle per read. Total read latency is 3 cycles.
  - o_rd_data holds its value when o_rd_valid=0.
- Address range:
  - A granted request with address >= ADDR_DEPTH is still acknowledged. Its memory command is suppressed (csn stays 1).
  - o_addr_err is set.
  - A suppressed read still produces o_rd_valid in c+3 with o_rd_data=0, so the read client's count stays aligned.
- Sticky flags:
  - o_starve is set on any S_WR_F entry.
  - Both flags clear on i_clr.
  - If i_clr and a set condition occur in the same cycle, set wins.
- Simultaneous requests: read wins unless force. On force the read is deferred one cycle, and the counter clears.
- Reset mid-operation: in-flight reads are dropped, with no o_rd_valid after reset release. The memory is idle the first cycle after release.

Test Plan:
- Reset release, both requests low:
  - Required: csn=1, wen=1, o_rd_valid=0, no grants for 10 cycles.
- Single write then read: wr addr 0x005, data 0xA5A5A5_5A5A5A_123456_FEDCBA, handshake at cycle c; read addr 0x005 at cycle c+2.
  - Required: csn=0/wen=0/addr=0x005 in c+1.
  - Required: o_rd_valid in c+5 with identical data.
- Read streaming: i_rd_req held high for 16 cycles, addr 0..15.
  - Required: 16 consecutive o_rd_gnt.
  - Required: o_rd_valid 16 consecutive cycles starting 3 cycles after the first handshake, data in address order.
- Starvation: i_rd_req and i_wr_req both high continuously, WR_MAX_WAIT=8.
  - Required: 8 read grants, then 1 write grant, repeating with period 9.
  - Required: o_starve=1 after first force; i_clr clears it only when no force occurs that cycle.
- Address error: read addr 19200 granted.
  - Required: csn stays 1, o_addr_err=1, o_rd_valid in c+3 with data 0.
  - Required: a following valid read is unaffected.
- Reset mid-read: assert rst_n low at cycle c+1 after a read handshake, release 2 cycles later.
  - Required: outputs at reset values immediately; no o_rd_valid after release.
